// File: rtl/glyph_pixel_serializer.sv
// ---------------------------------------------------------------------------
// glyph_pixel_serializer
//
// Purpose:
//   Takes one ASCII character code per handshake, drives it to the 5x7
//   character-bitmap ROM, latches the returned 35-bit glyph and emits it as
//   35 pixels (one COLOR_WIDTH-bit GRB colour each) over a valid/ready
//   stream towards the WS2812B bit encoder. Scan order is raster or
//   serpentine so the pixel stream matches the LED-matrix wiring.
//
// Parameters:
//   SERPENTINE   1: odd rows (1,3,5) go right-to-left; 0: all rows left-to-right
//   COLOR_WIDTH  pixel colour width (GRB, MSB first to the encoder)
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   char_valid  upstream character available
//   char_code   7-bit ASCII code
//   char_ready  serializer can accept a character (only in IDLE, never in reset)
//   fg_color    colour for set glyph bits, sampled at accept
//   bg_color    colour for clear glyph bits, sampled at accept
//   rom_addr    registered address to the character ROM
//   rom_data    glyph from the ROM (combinational from rom_addr)
//   pix_valid   pixel present
//   pix_ready   encoder accepts pixel
//   pix_rgb     pixel colour
//   pix_last    high with the 35th pixel of a glyph
// ---------------------------------------------------------------------------
module glyph_pixel_serializer #(
    parameter int SERPENTINE  = 1,
    parameter int COLOR_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   char_valid,
    input  logic [6:0]             char_code,
    output logic                   char_ready,
    input  logic [COLOR_WIDTH-1:0] fg_color,
    input  logic [COLOR_WIDTH-1:0] bg_color,
    output logic [6:0]             rom_addr,
    input  logic [34:0]            rom_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [COLOR_WIDTH-1:0] pix_rgb,
    output logic                   pix_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t                 state;
    logic [34:0]            glyph;
    logic [COLOR_WIDTH-1:0] fg_lat;
    logic [COLOR_WIDTH-1:0] bg_lat;
    logic [2:0]             row;
    logic [2:0]             col;

    // Next scan position after the pixel currently presented
    logic [2:0]             nrow;
    logic [2:0]             ncol;
    logic                   at_last;
    logic                   next_is_last;
    logic                   xfer;

    // Glyph bit for logical (r, c). Odd rows are mirrored in serpentine
    // mode; bit 34 is the top-left pixel.
    function automatic logic glyph_bit(input logic [34:0] g,
                                       input logic [2:0]  r,
                                       input logic [2:0]  c);
        logic [2:0] pc;
        logic [5:0] idx;
        pc  = ((SERPENTINE != 0) && r[0]) ? (3'd4 - c) : c;
        idx = 6'd34 - (6'(r) * 6'd5 + 6'(pc));
        return g[idx];
    endfunction

    assign char_ready = (state == IDLE) && !rst;
    assign xfer       = pix_valid && pix_ready;

    always_comb begin
        at_last = (row == 3'd6) && (col == 3'd4);
        if (col == 3'd4) begin
            nrow = row + 3'd1;
            ncol = 3'd0;
        end else begin
            nrow = row;
            ncol = col + 3'd1;
        end
        next_is_last = (nrow == 3'd6) && (ncol == 3'd4);
    end

    // pix_rgb/pix_last are registered: each is loaded one step ahead of the
    // position it describes, so the presented pixel only changes on a
    // transfer and stays stable through any stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            pix_valid <= 1'b0;
            pix_rgb   <= '0;
            pix_last  <= 1'b0;
            row       <= '0;
            col       <= '0;
            glyph     <= '0;
            fg_lat    <= '0;
            bg_lat    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        rom_addr <= char_code;
                        fg_lat   <= fg_color;
                        bg_lat   <= bg_color;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    glyph     <= rom_data;
                    row       <= '0;
                    col       <= '0;
                    pix_valid <= 1'b1;
                    pix_rgb   <= glyph_bit(rom_data, 3'd0, 3'd0) ? fg_lat : bg_lat;
                    pix_last  <= 1'b0;
                    state     <= EMIT;
                end

                EMIT: begin
                    if (xfer) begin
                        if (at_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            pix_rgb   <= '0;
                            row       <= '0;
                            col       <= '0;
                            state     <= IDLE;
                        end else begin
                            row      <= nrow;
                            col      <= ncol;
                            pix_rgb  <= glyph_bit(glyph, nrow, ncol) ? fg_lat : bg_lat;
                            pix_last <= next_is_last;
                        end
                    end
                end

                default: begin
                    pix_valid <= 1'b0;
                    pix_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_pixel_serializer.sv
// ---------------------------------------------------------------------------
// tb_glyph_pixel_serializer
//
// Directed bench for glyph_pixel_serializer. Two instances share all inputs:
// one raster (SERPENTINE=0) and one serpentine (SERPENTINE=1), each with its
// own copy of a small bench character ROM.
// ---------------------------------------------------------------------------
module tb_glyph_pixel_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_valid;
    logic [6:0]  char_code;
    logic [23:0] fg_color;
    logic [23:0] bg_color;
    logic        pix_ready;

    logic        cr_r, cr_s;
    logic [6:0]  ra_r, ra_s;
    logic [34:0] rd_r, rd_s;
    logic        pv_r, pv_s;
    logic [23:0] rgb_r, rgb_s;
    logic        pl_r, pl_s;

    logic [34:0] rom_mem [0:127];

    always #5 clk = ~clk;

    assign rd_r = rom_mem[ra_r];
    assign rd_s = rom_mem[ra_s];

    glyph_pixel_serializer #(.SERPENTINE(0), .COLOR_WIDTH(24)) u_rast (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
        .char_ready(cr_r), .fg_color(fg_color), .bg_color(bg_color),
        .rom_addr(ra_r), .rom_data(rd_r), .pix_valid(pv_r), .pix_ready(pix_ready),
        .pix_rgb(rgb_r), .pix_last(pl_r)
    );

    glyph_pixel_serializer #(.SERPENTINE(1), .COLOR_WIDTH(24)) u_serp (
        .clk(clk), .rst(rst), .char_valid(char_valid), .char_code(char_code),
        .char_ready(cr_s), .fg_color(fg_color), .bg_color(bg_color),
        .rom_addr(ra_s), .rom_data(rd_s), .pix_valid(pv_s), .pix_ready(pix_ready),
        .pix_rgb(rgb_s), .pix_last(pl_s)
    );

    int checks = 0;
    int errors = 0;

    logic [23:0] px_r [0:69];
    logic [23:0] px_s [0:69];
    logic        lr   [0:69];
    logic        ls   [0:69];
    int          first_cyc;
    int          ready_cycles;
    logic [6:0]  last_addr;

    localparam logic [34:0] G_A  = 35'h0_2000_0000;
    localparam logic [34:0] G_BR = 35'h0_0000_0001;
    localparam logic [34:0] G_55 = 35'h5_5555_5555;
    localparam logic [34:0] G_H  = 35'b10001_10001_10001_11111_10001_10001_10001;
    localparam logic [34:0] G_I  = 35'b01110_00100_00100_00100_00100_00100_01110;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected colour of stream pixel k (0..34) for glyph g
    function automatic logic [23:0] model(input logic [34:0] g, input int k, input int serp,
                                          input logic [23:0] fg, input logic [23:0] bg);
        int r, c, pc;
        logic [34:0] t;
        r  = k / 5;
        c  = k % 5;
        pc = (serp != 0 && (r % 2) == 1) ? 4 - c : c;
        t  = g >> (34 - (5 * r + pc));
        return t[0] ? fg : bg;
    endfunction

    // Present a character for one cycle; returns in FETCH, #1 after the accept edge
    task automatic send(input logic [6:0] code, input logic [23:0] fg, input logic [23:0] bg,
                        input bit hold);
        char_code  = code;
        fg_color   = fg;
        bg_color   = bg;
        char_valid = 1'b1;
        chk("idle_char_ready", cr_r, 1);
        @(posedge clk); #1;
        if (!hold) char_valid = 1'b0;
        chk("fetch_char_ready", cr_r, 0);
        chk("fetch_rom_addr_r", ra_r, code);
        chk("fetch_rom_addr_s", ra_s, code);
        chk("fetch_pix_valid", pv_r, 0);
    endtask

    // Gather n transfers; cycle 0 is the cycle the task starts in
    task automatic collect(input int n, input bit rnd, input int fg_cyc, input logic [23:0] fg_new);
        int cnt, cnt_s, cyc;
        bit stalled;
        logic [23:0] held;
        logic held_last;
        cnt = 0; cnt_s = 0; cyc = 0; stalled = 0; held = '0; held_last = 0;
        first_cyc = -1;
        ready_cycles = 0;
        while (cnt < n && cyc < 3000) begin
            if (cyc == fg_cyc) fg_color = fg_new;
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cr_r) ready_cycles++;
            if (stalled) begin
                chk("stall_valid", pv_r, 1);
                chk("stall_rgb", rgb_r, held);
                chk("stall_last", pl_r, held_last);
            end
            if (pv_r && pix_ready) begin
                px_r[cnt] = rgb_r;
                lr[cnt]   = pl_r;
                last_addr = ra_r;
                if (first_cyc < 0) first_cyc = cyc;
                cnt++;
            end
            if (pv_s && pix_ready) begin
                if (cnt_s < 70) begin
                    px_s[cnt_s] = rgb_s;
                    ls[cnt_s]   = pl_s;
                end
                cnt_s++;
            end
            stalled   = pv_r && !pix_ready;
            held      = rgb_r;
            held_last = pl_r;
            @(posedge clk); #1;
            cyc++;
        end
        pix_ready = 1'b1;
        chk("xfer_count_r", cnt, n);
        chk("xfer_count_s", cnt_s, n);
    endtask

    task automatic check_glyph(input string tag, input int base, input logic [34:0] g,
                               input logic [23:0] fg, input logic [23:0] bg);
        for (int k = 0; k < 35; k++) begin
            chk($sformatf("%s_rast_px%0d", tag, k), px_r[base + k], model(g, k, 0, fg, bg));
            chk($sformatf("%s_serp_px%0d", tag, k), px_s[base + k], model(g, k, 1, fg, bg));
            chk($sformatf("%s_rast_last%0d", tag, k), lr[base + k], (k == 34));
            chk($sformatf("%s_serp_last%0d", tag, k), ls[base + k], (k == 34));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) rom_mem[i] = '0;
        rom_mem[7'h41] = G_A;
        rom_mem[7'h42] = G_BR;
        rom_mem[7'h43] = G_55;
        rom_mem[7'h48] = G_H;
        rom_mem[7'h49] = G_I;

        rst = 1'b1; char_valid = 1'b0; char_code = '0;
        fg_color = '0; bg_color = '0; pix_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix_valid", pv_r, 0);
        chk("rst_pix_rgb", rgb_r, 0);
        chk("rst_pix_last", pl_r, 0);
        chk("rst_rom_addr", ra_r, 0);
        chk("rst_char_ready", cr_r, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_char_ready", cr_r, 1);
        @(posedge clk); #1;

        // Single set pixel: raster index 5, serpentine index 9
        send(7'h41, 24'hFF0000, 24'h000000, 0);
        collect(35, 0, -1, '0);
        chk("first_pixel_latency", first_cyc, 1);
        check_glyph("A", 0, G_A, 24'hFF0000, 24'h000000);
        chk("A_rast_px5", px_r[5], 24'hFF0000);
        chk("A_rast_px9", px_r[9], 24'h000000);
        chk("A_serp_px9", px_s[9], 24'hFF0000);
        chk("A_serp_px5", px_s[5], 24'h000000);
        chk("end_pix_valid", pv_r, 0);
        chk("end_char_ready", cr_r, 1);

        // Bottom-right pixel: row 6 is not mirrored
        send(7'h42, 24'hFF0000, 24'h000000, 0);
        collect(35, 0, -1, '0);
        check_glyph("BR", 0, G_BR, 24'hFF0000, 24'h000000);
        chk("BR_serp_px34", px_s[34], 24'hFF0000);
        chk("BR_rast_px34", px_r[34], 24'hFF0000);

        // Random backpressure
        send(7'h43, 24'h123456, 24'h654321, 0);
        collect(35, 1, -1, '0);
        check_glyph("BP", 0, G_55, 24'h123456, 24'h654321);

        // fg changes after accept must not reach the in-flight glyph
        send(7'h48, 24'h00FF00, 24'h000010, 0);
        collect(35, 0, 2, 24'h0000FF);
        check_glyph("COL1", 0, G_H, 24'h00FF00, 24'h000010);
        send(7'h48, fg_color, 24'h000010, 0);
        collect(35, 0, -1, '0);
        check_glyph("COL2", 0, G_H, 24'h0000FF, 24'h000010);

        // Back-to-back with char_valid held high
        send(7'h48, 24'hA0A0A0, 24'h0B0B0B, 1);
        char_code = 7'h49;
        collect(70, 0, -1, '0);
        char_valid = 1'b0;
        chk("b2b_ready_cycles", ready_cycles, 1);
        chk("b2b_second_addr", last_addr, 7'h49);
        check_glyph("B2B1", 0, G_H, 24'hA0A0A0, 24'h0B0B0B);
        check_glyph("B2B2", 35, G_I, 24'hA0A0A0, 24'h0B0B0B);

        // Control code passes to the ROM unfiltered
        @(posedge clk); #1;
        send(7'h05, 24'hFFFFFF, 24'h0C0C0C, 0);
        collect(35, 0, -1, '0);
        check_glyph("CTRL", 0, 35'h0, 24'hFFFFFF, 24'h0C0C0C);

        // Reset in the middle of a glyph (pixel 10 presented)
        send(7'h43, 24'hAABBCC, 24'h112233, 0);
        collect(10, 0, -1, '0);
        chk("mid_pix_valid", pv_r, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pix_valid_r", pv_r, 0);
        chk("midrst_pix_valid_s", pv_s, 0);
        chk("midrst_pix_rgb", rgb_r, 0);
        chk("midrst_pix_last", pl_r, 0);
        chk("midrst_char_ready", cr_r, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("after_rst_char_ready", cr_r, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("after_rst_no_pixel", pv_r, 0);
            chk("after_rst_no_last", pl_r, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glyph_pixel_serializer.md
Name: glyph_pixel_serializer

Overview:
- Downstream consumer of the 5x7 character-bitmap ROM in the WS2812B text peripheral.
- Accepts one ASCII character code per handshake and drives the ROM address.
- Latches the returned 35-bit glyph and emits 35 pixels, one 24-bit GRB colour each, to the WS2812B bit encoder over a valid/ready stream.
- Scan order is raster or serpentine, chosen to match LED-matrix wiring.

Parameters:
- SERPENTINE, 1, when 1 odd rows (1, 3, 5) are emitted right-to-left; when 0 every row is emitted left-to-right.
- COLOR_WIDTH, 24, pixel colour width (GRB, MSB first to encoder).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- char_valid  in  1  upstream character available.
- char_code  in  7  ASCII code.
- char_ready  out  1  serializer can accept a character.
- fg_color  in  COLOR_WIDTH  colour for set bits, sampled at accept.
- bg_color  in  COLOR_WIDTH  colour for clear bits, sampled at accept.
- rom_addr  out  7  address to char ROM (registered).
- rom_data  in  35  glyph from ROM (combinational from rom_addr).
- pix_valid  out  1  pixel present.
- pix_ready  in  1  encoder accepts pixel.
- pix_rgb  out  COLOR_WIDTH  pixel colour.
- pix_last  out  1  high with the 35th pixel of a glyph.

Behaviour:
- Clocking and reset: single clock, all state on rising edge of clk. Reset is synchronous, active-high (rst).
- Reset values: state=IDLE, rom_addr=0, pix_valid=0, pix_rgb=0, pix_last=0, row=0, col=0, glyph register=0, colour latches=0. While rst=1, char_ready=0.
- Glyph bit mapping: pixel at (row r 0..6 top-down, column c 0..4 left-right) is rom_data[34 - (5r + c)]. Bit 34 is the top-left pixel.
- IDLE:
  - char_ready=1.
  - On char_valid&&char_ready: rom_addr<=char_code, fg/bg latched, go FETCH.
- FETCH (one cycle):
  - char_ready=0.
  - Glyph register<=rom_data, row<=0, col<=0, go EMIT.
- EMIT:
  - pix_valid=1.
  - pix_rgb = glyph bit for (row, physical column) ? fg : bg.
  - Physical column = (SERPENTINE && row[0]) ? 4-col : col.
- Handshake:
  - Pixel transfers on pix_valid&&pix_ready.
  - While pix_ready=0, pix_rgb/pix_last are held stable and pix_valid stays 1. No pixel may be dropped or repeated.
- Advance on each transfer:
  - If col<4, col+1.
  - Else col=0, row+1.
- End of glyph:
  - pix_last=1 exactly when row=6 and col=4.
  - On that transfer: pix_valid<=0, go IDLE.
  - char_ready returns 1 the next cycle; there is no back-to-back accept in the same cycle.
- Latency: accept at cycle T, FETCH at T+1, first pixel valid at T+2. Full glyph takes a minimum of 37 cycles (accept, fetch, 35 pixels).
- Input timing: fg/bg changes after accept have no effect on the in-flight glyph. char_code is ignored outside IDLE.
- ROM addressing: any 7-bit code is passed to the ROM unchanged. The serializer does not filter codes below 32.
- Reset mid-glyph: rst=1 in any state returns to IDLE with reset values on the next edge. No pix_last is emitted for the aborted glyph.
- rom_data is sampled only in FETCH. Changes in other states are ignored.

Test Plan:
- Reset: hold rst 2 cycles mid-EMIT (pixel 10) -> next cycle pix_valid=0, pix_rgb=0, pix_last=0. First cycle after rst low: char_ready=1.
- Raster order (SERPENTINE=0): bench ROM returns 35'h0_2000_0000 (bit 29 only) for code 0x41, fg=24'hFF0000, bg=24'h000000, pix_ready=1 -> pixel index 5 is FF0000, all other 34 pixels 000000. First pix_valid 2 cycles after accept. pix_last only on pixel 34.
- Serpentine (SERPENTINE=1): same glyph -> only pixel index 9 is FF0000. Also 35'h0_0000_0001 (bottom-right) -> only pixel index 34 set. Row 6 is even, so no reversal.
- Backpressure: random pix_ready (about 50%) with glyph 35'h5_5555_5555 -> exactly 35 transfers. pix_rgb is stable across stalled cycles and the sequence matches the model. 35 transfers occur regardless of stall pattern.
- Colour sampling: change fg from 24'h00FF00 to 24'h0000FF at cycle T+3 -> all set pixels of that glyph stay 00FF00. The next glyph uses 0000FF.
- Back-to-back characters with char_valid held high for 0x48, 0x49 -> rom_addr=0x48 then 0x49. char_ready=0 from FETCH through the pix_last transfer. Exactly 70 pixels; pix_last on pixels 35 and 70.
